// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter in front of a shared N-to-1 mux. One requester is granted
//   at a time. Its W-bit slice of x is streamed to a single consumer over a
//   valid/ready handshake. A grant is released when the requester withdraws or
//   after MAX_HOLD transfers. On release the priority pointer moves just past the
//   released requester, and a new winner is granted in the same cycle.
// Ports
//   clk      : rising-edge clock
//   n_reset  : synchronous active-low reset
//   req      : N request bits
//   x        : packed mux inputs, input i = x[i*W +: W]
//   y_ready  : consumer accepts y this cycle
//   y        : selected data while granted, else 0
//   y_valid  : granted and the granted requester still requests
//   gnt      : registered one-hot grant (zero when idle)
//   sel      : registered mux select, index of the gnt bit
//   busy     : arbiter is in the GRANT state
module mux_rr_arbiter #(
  parameter int N        = 8,
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                                 clk,
  input  logic                                 n_reset,
  input  logic [N-1:0]                         req,
  input  logic [N*W-1:0]                       x,
  input  logic                                 y_ready,
  output logic [W-1:0]                         y,
  output logic                                 y_valid,
  output logic [N-1:0]                         gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] sel,
  output logic                                 busy
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_n;
  logic [SW-1:0]  ptr, ptr_n;
  logic [HW-1:0]  hold_cnt, hold_n;
  logic [N-1:0]   gnt_n;
  logic [SW-1:0]  sel_n;

  logic           xfer;
  logic           release_g;
  logic [SW-1:0]  sel_inc;
  logic [SW-1:0]  scan_ptr;
  logic           found;
  logic [SW-1:0]  win;

  // First set request at or after p, with wrap-around. Result is {found, index}.
  function automatic logic [SW:0] find_winner(input logic [N-1:0] r,
                                              input logic [SW-1:0] p);
    logic [SW:0]  res;
    int unsigned  k;
    res = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = 32'(p) + i;
      if (k >= 32'(N)) k = k - 32'(N);
      if (!res[SW] && r[k[SW-1:0]]) begin
        res = {1'b1, k[SW-1:0]};
      end
    end
    return res;
  endfunction

  always_comb begin
    busy    = (state == GRANT);
    y_valid = busy && req[sel];
    y       = busy ? x[int'(sel)*W +: W] : '0;
  end

  always_comb begin
    xfer      = y_valid && y_ready;
    sel_inc   = (sel == SW'(N - 1)) ? '0 : sel + 1'b1;
    // A withdrawal takes precedence: if req[sel] is low there is no transfer,
    // so the quota condition cannot also fire.
    release_g = busy && (!req[sel] || (xfer && hold_cnt == HW'(MAX_HOLD - 1)));
    // On release the search already uses the advanced pointer. This gives a
    // back-to-back regrant with no idle bubble.
    scan_ptr  = release_g ? sel_inc : ptr;
    {found, win} = find_winner(req, scan_ptr);
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    sel_n   = sel;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          gnt_n   = {{(N-1){1'b0}}, 1'b1} << win;
          sel_n   = win;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (release_g) begin
          ptr_n  = sel_inc;
          hold_n = '0;
          if (found) begin
            gnt_n = {{(N-1){1'b0}}, 1'b1} << win;
            sel_n = win;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            sel_n   = '0;
          end
        end else if (xfer) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
//   Directed scenarios followed by a randomized phase. Every cycle is compared
//   against a behavioural round-robin model that keeps the grant owner, the
//   priority start index and the transfer count as plain integers.
module tb_mux_rr_arbiter;
  localparam int N        = 8;
  localparam int W        = 1;
  localparam int MAX_HOLD = 4;
  localparam int SW       = $clog2(N);

  logic            clk = 1'b0;
  logic            n_reset;
  logic [N-1:0]    req;
  logic [N*W-1:0]  x;
  logic            y_ready;
  logic [W-1:0]    y;
  logic            y_valid;
  logic [N-1:0]    gnt;
  logic [SW-1:0]   sel;
  logic            busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_cnt;

  mux_rr_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .req     (req),
    .x       (x),
    .y_ready (y_ready),
    .y       (y),
    .y_valid (y_valid),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic int winner(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // The model applies the arbitration rules at a rising edge, using the inputs
  // that were held during the cycle.
  task automatic model_edge();
    int  w;
    bit  xf;
    bit  rel;
    if (!n_reset) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      w = winner(req, m_ptr);
      if (w >= 0) begin
        m_busy = 1; m_sel = w; m_cnt = 0;
      end
    end else begin
      xf  = req[m_sel] && y_ready;
      rel = !req[m_sel] || (xf && m_cnt == MAX_HOLD - 1);
      if (rel) begin
        m_ptr = (m_sel + 1) % N;
        w = winner(req, m_ptr);
        m_cnt = 0;
        if (w >= 0) m_sel = w;
        else begin
          m_busy = 0; m_sel = 0;
        end
      end else if (xf) begin
        m_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Mid-cycle comparison of all outputs against the model, plus invariants.
  task automatic sample();
    logic [N-1:0] eg;
    logic [W-1:0] ey;
    logic         ev;
    #4;
    eg = m_busy ? (N'(1) << m_sel) : '0;
    ev = m_busy && req[m_sel];
    ey = m_busy ? x[m_sel*W +: W] : '0;
    chk("gnt",     32'(gnt),     32'(eg));
    chk("busy",    32'(busy),    32'(m_busy));
    chk("y_valid", 32'(y_valid), 32'(ev));
    chk("y",       32'(y),       32'(ey));
    if (m_busy) chk("sel", 32'(sel), 32'(m_sel));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'(1));
    if (busy) chk("gnt_eq_sel", 32'(gnt), 32'(N'(1) << sel));
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
  endtask

  initial begin
    x       = 8'b10101100;
    y_ready = 1'b0;

    // 1. Reset with all requests asserted, then release.
    n_reset = 1'b0;
    req     = 8'hFF;
    tick();
    sample();
    chk("t1_rst_gnt", 32'(gnt), 32'h0);
    chk("t1_rst_yv",  32'(y_valid), 32'h0);
    chk("t1_rst_y",   32'(y), 32'h0);
    n_reset = 1'b1;
    tick();
    sample();
    chk("t1_gnt", 32'(gnt), 32'h01);
    chk("t1_sel", 32'(sel), 32'h0);
    chk("t1_y",   32'(y), 32'h0);

    // 2. Two requesters alternate after four transfers each.
    do_reset();
    req = 8'h24; y_ready = 1'b1;
    sample(); tick();
    for (int k = 0; k < 4; k++) begin
      sample(); chk("t2_gnt_a", 32'(gnt), 32'h04); chk("t2_y_a", 32'(y), 32'h1); tick();
    end
    for (int k = 0; k < 4; k++) begin
      sample(); chk("t2_gnt_b", 32'(gnt), 32'h20); chk("t2_y_b", 32'(y), 32'h1); tick();
    end
    sample(); chk("t2_gnt_c", 32'(gnt), 32'h04);

    // 3. Stall holds the grant; the quota then lasts exactly four transfers.
    do_reset();
    req = 8'h08; y_ready = 1'b0;
    sample(); tick();
    req = 8'h09;
    for (int k = 0; k < 5; k++) begin
      sample(); chk("t3_stall_gnt", 32'(gnt), 32'h08);
      chk("t3_stall_yv", 32'(y_valid), 32'h1); chk("t3_stall_y", 32'(y), 32'h1); tick();
    end
    y_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample(); chk("t3_xfer_gnt", 32'(gnt), 32'h08); tick();
    end
    sample(); chk("t3_rot_gnt", 32'(gnt), 32'h01);

    // 4. Early withdrawal moves on to the next requester, then to idle.
    do_reset();
    req = 8'h40;
    sample(); tick();
    sample(); chk("t4_gnt6", 32'(gnt), 32'h40); tick();
    req = 8'h06;
    sample(); chk("t4_wd_yv", 32'(y_valid), 32'h0); tick();
    sample(); chk("t4_next_gnt", 32'(gnt), 32'h02);
    req = 8'h00;
    tick();
    sample(); chk("t4_idle_gnt", 32'(gnt), 32'h0); chk("t4_idle_busy", 32'(busy), 32'h0);

    // 5. Reset in the middle of a grant; arbitration restarts at index 0.
    req = 8'hFF; y_ready = 1'b0;
    tick(); sample(); tick(); sample();
    chk("t5_busy_before", 32'(busy), 32'h1);
    n_reset = 1'b0;
    tick();
    sample(); chk("t5_rst_gnt", 32'(gnt), 32'h0); chk("t5_rst_busy", 32'(busy), 32'h0);
    n_reset = 1'b1;
    req = 8'h81;
    tick();
    sample(); chk("t5_rearb_gnt", 32'(gnt), 32'h01);

    // 6. Lone requester is regranted at every quota boundary.
    do_reset();
    req = 8'h80; y_ready = 1'b1;
    sample(); tick();
    for (int k = 0; k < 10; k++) begin
      sample(); chk("t6_gnt", 32'(gnt), 32'h80); chk("t6_y", 32'(y), 32'h1); tick();
    end

    // Randomized phase
    for (int k = 0; k < 600; k++) begin
      n_reset = ($urandom_range(0, 59) != 0);
      case ($urandom_range(0, 3))
        0:       req = '0;
        1:       req = N'($urandom);
        default: req = N'($urandom) & N'($urandom);
      endcase
      y_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) x = (N*W)'($urandom);
      sample();
      tick();
    end
    sample();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
